// File: rtl/piano_tone_gen.sv
// Keyboard-byte driven square-wave tone generator with octave shift,
// stop command and a re-triggerable sustain timer.
module piano_tone_gen #(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned OCT_MAX     = 2
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       audio_out,
  output logic       note_active,
  output logic [3:0] note_idx,
  output logic [1:0] octave
);

  localparam int unsigned CNT_W  = 18;
  localparam int unsigned HOLD_W = 25;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]        OCT_TOP   = 2'(OCT_MAX);

  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_UP    = 8'h78;  // 'x'
  localparam logic [7:0] KEY_DOWN  = 8'h7A;  // 'z'

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [3:0]          r_note_idx;
  logic [1:0]          r_octave;
  logic [CNT_W-1:0]    r_tone_cnt;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_audio;
  logic                r_note_active;

  logic                w_key_hit;
  logic [3:0]          w_key;
  logic                w_note_vld;
  logic                w_stop_vld;
  logic                w_up_vld;
  logic                w_down_vld;
  logic                w_same_note;
  logic [CNT_W-1:0]    w_base;
  logic [CNT_W-1:0]    w_half;
  logic [CNT_W-1:0]    w_half_m1;
  logic                w_hold_zero;

  logic                w_start;
  logic                w_reload;
  logic                w_run;
  logic                w_halt;

  // Map lowercase piano keys to note indices
  always_comb begin
    w_key_hit = 1'b1;
    w_key     = 4'd0;
    case (data)
      8'h61:   w_key = 4'd0;   // a
      8'h77:   w_key = 4'd1;   // w
      8'h73:   w_key = 4'd2;   // s
      8'h65:   w_key = 4'd3;   // e
      8'h64:   w_key = 4'd4;   // d
      8'h66:   w_key = 4'd5;   // f
      8'h74:   w_key = 4'd6;   // t
      8'h67:   w_key = 4'd7;   // g
      8'h79:   w_key = 4'd8;   // y
      8'h68:   w_key = 4'd9;   // h
      8'h75:   w_key = 4'd10;  // u
      8'h6A:   w_key = 4'd11;  // j
      8'h6B:   w_key = 4'd12;  // k
      default: w_key_hit = 1'b0;
    endcase
  end

  assign w_note_vld  = data_valid & w_key_hit;
  assign w_stop_vld  = data_valid & (data == KEY_SPACE);
  assign w_up_vld    = data_valid & (data == KEY_UP);
  assign w_down_vld  = data_valid & (data == KEY_DOWN);
  assign w_same_note = (w_key == r_note_idx);
  assign w_hold_zero = (r_hold == '0);

  // Base half-period of the current note at octave 0
  always_comb begin
    w_base = 18'd191110;
    case (r_note_idx)
      4'd0:    w_base = 18'd191110;
      4'd1:    w_base = 18'd180388;
      4'd2:    w_base = 18'd170265;
      4'd3:    w_base = 18'd160705;
      4'd4:    w_base = 18'd151685;
      4'd5:    w_base = 18'd143172;
      4'd6:    w_base = 18'd135139;
      4'd7:    w_base = 18'd127551;
      4'd8:    w_base = 18'd120395;
      4'd9:    w_base = 18'd113636;
      4'd10:   w_base = 18'd107260;
      4'd11:   w_base = 18'd101239;
      4'd12:   w_base = 18'd95557;
      default: w_base = 18'd191110;
    endcase
  end

  assign w_half    = w_base >> r_octave;
  assign w_half_m1 = w_half - CNT_W'(1);

  // State register
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a note byte always wins over stop/expiry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_note_vld) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (w_note_vld)                     w_state_nxt = S_PLAY;
        else if (w_stop_vld || w_hold_zero) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath control strobes per state
  always_comb begin
    w_start  = 1'b0;
    w_reload = 1'b0;
    w_run    = 1'b0;
    w_halt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = w_note_vld;
      end
      S_PLAY: begin
        if (w_note_vld && w_same_note) begin
          w_reload = 1'b1;
          w_run    = 1'b1;
        end else if (w_note_vld) begin
          w_start = 1'b1;
        end else if (w_stop_vld || w_hold_zero) begin
          w_halt = 1'b1;
        end else begin
          w_run = 1'b1;
        end
      end
    endcase
  end

  // Note index, tone phase counter, square-wave output and sustain timer
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_note_idx    <= '0;
      r_tone_cnt    <= '0;
      r_hold        <= '0;
      r_audio       <= 1'b0;
      r_note_active <= 1'b0;
    end else begin
      r_note_active <= (w_state_nxt == S_PLAY);
      if (w_start) begin
        r_note_idx <= w_key;
        r_tone_cnt <= '0;
        r_audio    <= 1'b1;
        r_hold     <= HOLD_LOAD;
      end else if (w_halt) begin
        r_tone_cnt <= '0;
        r_audio    <= 1'b0;
        r_hold     <= '0;
      end else begin
        if (w_run) begin
          // >= so a shorter half-period after an octave change never overshoots
          if (r_tone_cnt >= w_half_m1) begin
            r_tone_cnt <= '0;
            r_audio    <= ~r_audio;
          end else begin
            r_tone_cnt <= r_tone_cnt + CNT_W'(1);
          end
        end
        if (w_reload) begin
          r_hold <= HOLD_LOAD;
        end else if (w_run) begin
          r_hold <= r_hold - HOLD_W'(1);
        end
      end
    end
  end

  // Saturating octave shift
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_octave <= '0;
    end else if (w_up_vld && (r_octave < OCT_TOP)) begin
      r_octave <= r_octave + 2'd1;
    end else if (w_down_vld && (r_octave != 2'd0)) begin
      r_octave <= r_octave - 2'd1;
    end
  end

  assign audio_out   = r_audio;
  assign note_active = r_note_active;
  assign note_idx    = r_note_idx;
  assign octave      = r_octave;

endmodule

// File: tb/tb_piano_tone_gen.sv
// Self-checking bench for piano_tone_gen against a cycle-stamped event model.
module tb_piano_tone_gen;

  localparam int HOLD = 2000;
  localparam int OCTM = 3;

  logic       clk_fpga;
  logic       reset;
  logic [7:0] data;
  logic       data_valid;
  logic       audio_out;
  logic       note_active;
  logic [3:0] note_idx;
  logic [1:0] octave;

  int checks;
  int errors;

  // Model state: notes described by start/last-accept timestamps
  longint t;
  longint m_last;
  longint m_ps;
  bit     m_active;
  bit     m_audio;
  int     m_idx;
  int     m_oct;
  int     m_half;

  int unsigned BASE [13] = '{191110, 180388, 170265, 160705, 151685, 143172,
                             135139, 127551, 120395, 113636, 107260, 101239, 95557};
  logic [7:0]  KEYS [13] = '{8'h61, 8'h77, 8'h73, 8'h65, 8'h64, 8'h66, 8'h74,
                             8'h67, 8'h79, 8'h68, 8'h75, 8'h6A, 8'h6B};

  piano_tone_gen #(
    .HOLD_CYCLES(HOLD),
    .OCT_MAX    (OCTM)
  ) dut (
    .clk_fpga   (clk_fpga),
    .reset      (reset),
    .data       (data),
    .data_valid (data_valid),
    .audio_out  (audio_out),
    .note_active(note_active),
    .note_idx   (note_idx),
    .octave     (octave)
  );

  initial clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  function automatic int key_of(input logic [7:0] b);
    for (int i = 0; i < 13; i++) begin
      if (KEYS[i] == b) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pick_ignored();
    logic [7:0] b;
    do b = 8'($urandom); while (key_of(b) >= 0 || b == 8'h20 || b == 8'h78 || b == 8'h7A);
    return b;
  endfunction

  // Advance one clock; update the model with the inputs sampled at that edge
  task automatic tick();
    int key;
    bit play;
    @(negedge clk_fpga);
    t++;
    key = key_of(data);
    if (reset) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_oct    = 0;
    end else begin
      play = m_active;
      if (data_valid && key >= 0) begin
        if (play && key == m_idx) begin
          m_last = t;
        end else begin
          m_idx    = key;
          m_ps     = t;
          m_last   = t;
          m_half   = int'(BASE[key] >> m_oct);
          m_active = 1'b1;
        end
      end else if (data_valid && data == 8'h20) begin
        m_active = 1'b0;
      end else begin
        if (data_valid && data == 8'h78 && m_oct < OCTM) m_oct++;
        if (data_valid && data == 8'h7A && m_oct > 0) m_oct--;
        if (play && (t - m_last >= longint'(HOLD))) m_active = 1'b0;
      end
    end
    m_audio = m_active && (((t - m_ps) / longint'(m_half)) % 2 == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data       = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data       = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; data = 8'h61; data_valid = 1'b1;
    repeat (3) tick();
    data_valid = 1'b0;
    checks++;
    if ({audio_out, note_active, note_idx, octave} !== 8'h00) begin
      errors++; $display("FAIL reset_init: got %b exp 00000000", {audio_out, note_active, note_idx, octave});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({audio_out, note_active, note_idx, octave} !== 8'h00) begin
      errors++; $display("FAIL reset_release: got %b exp 00000000", {audio_out, note_active, note_idx, octave});
    end
    send_byte(8'h78);
    send_byte(8'h73);
    repeat (10) tick();
    checks++;
    if ({note_active, note_idx, octave} !== {1'b1, 4'd2, 2'd1}) begin
      errors++; $display("FAIL reset_prenote: got act=%b idx=%0d oct=%0d exp 1 2 1", note_active, note_idx, octave);
    end
    reset = 1'b1; data = 8'h64; data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({audio_out, note_active, note_idx, octave} !== 8'h00) begin
        errors++; $display("FAIL reset_mid cyc%0d: got %b exp 00000000", i, {audio_out, note_active, note_idx, octave});
      end
    end
    reset = 1'b0; data_valid = 1'b0; data = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({audio_out, note_active} !== 2'b00) begin
        errors++; $display("FAIL reset_quiet cyc%0d: got aud=%b act=%b exp 0 0", i, audio_out, note_active);
      end
    end
  endtask

  task automatic test_single_note();
    send_byte(8'h68);
    checks++;
    if ({note_active, note_idx, audio_out} !== {1'b1, 4'd9, 1'b1}) begin
      errors++; $display("FAIL single_start: got act=%b idx=%0d aud=%b exp 1 9 1", note_active, note_idx, audio_out);
    end
    for (int k = 1; k <= 200; k++) begin
      tick();
      checks++;
      if (audio_out !== m_audio || note_active !== m_active) begin
        errors++; $display("FAIL single_run k=%0d: got aud=%b act=%b exp %b %b", k, audio_out, note_active, m_audio, m_active);
      end
    end
    send_byte(8'h20);
    checks++;
    if ({note_active, audio_out, note_idx} !== {1'b0, 1'b0, 4'd9}) begin
      errors++; $display("FAIL single_stop: got act=%b aud=%b idx=%0d exp 0 0 9", note_active, audio_out, note_idx);
    end
  endtask

  task automatic test_octave();
    int exp_oct;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h78);
      exp_oct = (i + 1 > OCTM) ? OCTM : i + 1;
      checks++;
      if (octave !== 2'(exp_oct)) begin
        errors++; $display("FAIL oct_up%0d: got %0d exp %0d", i, octave, exp_oct);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h7A);
      exp_oct = (OCTM - (i + 1) < 0) ? 0 : OCTM - (i + 1);
      checks++;
      if (octave !== 2'(exp_oct)) begin
        errors++; $display("FAIL oct_down%0d: got %0d exp %0d", i, octave, exp_oct);
      end
    end
    // octave keys mid-note must not disturb the sustain timer
    send_byte(8'h61);
    for (int k = 1; k <= 2005; k++) begin
      data_valid = 1'b0;
      if (k == 100) begin data = 8'h78; data_valid = 1'b1; end
      if (k == 200) begin data = 8'h7A; data_valid = 1'b1; end
      tick();
      checks++;
      if (note_active !== (k < HOLD)) begin
        errors++; $display("FAIL oct_hold k=%0d: got %b exp %b", k, note_active, (k < HOLD));
      end
      if (k == 100 || k == 200) begin
        checks++;
        if (octave !== 2'((k == 100) ? 1 : 0)) begin
          errors++; $display("FAIL oct_midnote k=%0d: got %0d exp %0d", k, octave, (k == 100) ? 1 : 0);
        end
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_tone();
    repeat (3) send_byte(8'h78);
    send_byte(8'h6B);
    checks++;
    if ({octave, note_idx, audio_out} !== {2'd3, 4'd12, 1'b1}) begin
      errors++; $display("FAIL tone_start: got oct=%0d idx=%0d aud=%b exp 3 12 1", octave, note_idx, audio_out);
    end
    for (int k = 1; k <= 12000; k++) begin
      data_valid = 1'b0;
      if (k % 1000 == 0) begin data = 8'h6B; data_valid = 1'b1; end
      tick();
      checks++;
      if (audio_out !== m_audio || note_active !== m_active) begin
        errors++; $display("FAIL tone_k k=%0d: got aud=%b act=%b exp %b %b", k, audio_out, note_active, m_audio, m_active);
      end
      if (k == 11943 || k == 11944) begin
        checks++;
        if (audio_out !== (k == 11943)) begin
          errors++; $display("FAIL tone_k_edge k=%0d: got %b exp %b", k, audio_out, (k == 11943));
        end
      end
    end
    data_valid = 1'b0;
    // switching notes while the wave is low restarts the phase high
    send_byte(8'h6A);
    checks++;
    if ({note_idx, audio_out, note_active} !== {4'd11, 1'b1, 1'b1}) begin
      errors++; $display("FAIL tone_switch: got idx=%0d aud=%b act=%b exp 11 1 1", note_idx, audio_out, note_active);
    end
    for (int k = 1; k <= 25310; k++) begin
      data_valid = 1'b0;
      if (k % 1000 == 0) begin data = 8'h6A; data_valid = 1'b1; end
      tick();
      checks++;
      if (audio_out !== m_audio || note_active !== m_active) begin
        errors++; $display("FAIL tone_j k=%0d: got aud=%b act=%b exp %b %b", k, audio_out, note_active, m_audio, m_active);
      end
      if (k == 12653 || k == 12654 || k == 25307 || k == 25308) begin
        checks++;
        if (audio_out !== (k == 12653 || k == 25308)) begin
          errors++; $display("FAIL tone_j_edge k=%0d: got %b exp %b", k, audio_out, (k == 12653 || k == 25308));
        end
      end
    end
    data_valid = 1'b0;
    send_byte(8'h20);
    checks++;
    if ({note_active, audio_out} !== 2'b00) begin
      errors++; $display("FAIL tone_stop: got act=%b aud=%b exp 0 0", note_active, audio_out);
    end
  endtask

  task automatic test_retrigger();
    repeat (3) send_byte(8'h7A);
    send_byte(8'h61);
    for (int k = 1; k <= 3605; k++) begin
      data_valid = 1'b0;
      if (k == 1600) begin data = 8'h61; data_valid = 1'b1; end
      tick();
      checks++;
      if (note_active !== (k < 1600 + HOLD) || audio_out !== (k < 1600 + HOLD)) begin
        errors++; $display("FAIL retrig k=%0d: got act=%b aud=%b exp %b", k, note_active, audio_out, (k < 1600 + HOLD));
      end
    end
    data_valid = 1'b0;
    send_byte(8'h61);
    repeat (50) tick();
    send_byte(8'h64);
    checks++;
    if ({note_idx, audio_out, note_active} !== {4'd4, 1'b1, 1'b1}) begin
      errors++; $display("FAIL retrig_switch: got idx=%0d aud=%b act=%b exp 4 1 1", note_idx, audio_out, note_active);
    end
    send_byte(8'h20);
  endtask

  task automatic test_stop_ignore();
    send_byte(8'h67);
    send_byte(8'h41);
    checks++;
    if ({note_active, note_idx, audio_out, octave} !== {1'b1, 4'd7, 1'b1, 2'd0}) begin
      errors++; $display("FAIL ignore_A: got act=%b idx=%0d aud=%b oct=%0d exp 1 7 1 0", note_active, note_idx, audio_out, octave);
    end
    for (int i = 0; i < 5; i++) begin
      send_byte(pick_ignored());
      checks++;
      if ({note_active, note_idx, audio_out, octave} !== {1'b1, 4'd7, 1'b1, 2'd0}) begin
        errors++; $display("FAIL ignore_rand%0d: got act=%b idx=%0d aud=%b oct=%0d exp 1 7 1 0", i, note_active, note_idx, audio_out, octave);
      end
    end
    send_byte(8'h20);
    checks++;
    if ({note_active, audio_out, note_idx} !== {1'b0, 1'b0, 4'd7}) begin
      errors++; $display("FAIL stop: got act=%b aud=%b idx=%0d exp 0 0 7", note_active, audio_out, note_idx);
    end
  endtask

  task automatic test_boundary();
    send_byte(8'h66);
    // same note on the expiry edge keeps it sounding
    for (int k = 1; k <= HOLD; k++) begin
      data_valid = 1'b0;
      if (k == HOLD) begin data = 8'h66; data_valid = 1'b1; end
      tick();
      checks++;
      if (note_active !== 1'b1 || audio_out !== m_audio) begin
        errors++; $display("FAIL bound_same k=%0d: got act=%b aud=%b exp 1 %b", k, note_active, audio_out, m_audio);
      end
    end
    // different note on the expiry edge starts it
    for (int k = 1; k <= HOLD; k++) begin
      data_valid = 1'b0;
      if (k == HOLD) begin data = 8'h67; data_valid = 1'b1; end
      tick();
      checks++;
      if (note_active !== 1'b1) begin
        errors++; $display("FAIL bound_diff k=%0d: got act=%b exp 1", k, note_active);
      end
    end
    data_valid = 1'b0;
    checks++;
    if ({note_idx, audio_out} !== {4'd7, 1'b1}) begin
      errors++; $display("FAIL bound_diff_note: got idx=%0d aud=%b exp 7 1", note_idx, audio_out);
    end
    for (int k = 1; k <= HOLD + 1; k++) begin
      tick();
      checks++;
      if (note_active !== (k < HOLD)) begin
        errors++; $display("FAIL bound_expire k=%0d: got %b exp %b", k, note_active, (k < HOLD));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int c = 0; c < 4000; c++) begin
      data_valid = 1'b0;
      data       = 8'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 5)       b = KEYS[$urandom_range(0, 12)];
        else if (r == 5) b = 8'h20;
        else if (r == 6) b = 8'h78;
        else if (r == 7) b = 8'h7A;
        else             b = pick_ignored();
        if ((b == 8'h78 || b == 8'h7A) && m_active) b = 8'h41;
        data       = b;
        data_valid = 1'b1;
      end
      tick();
      checks++;
      if (audio_out !== m_audio || note_active !== m_active ||
          note_idx !== 4'(m_idx) || octave !== 2'(m_oct)) begin
        errors++;
        $display("FAIL random c=%0d: got aud=%b act=%b idx=%0d oct=%0d exp %b %b %0d %0d",
                 c, audio_out, note_active, note_idx, octave, m_audio, m_active, m_idx, m_oct);
      end
    end
    data_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data       = 8'h00;
    checks     = 0;
    errors     = 0;
    t          = 0;
    m_last     = 0;
    m_ps       = 0;
    m_active   = 1'b0;
    m_audio    = 1'b0;
    m_idx      = 0;
    m_oct      = 0;
    m_half     = 1;
    test_reset();
    test_single_note();
    test_octave();
    test_tone();
    test_retrigger();
    test_stop_ignore();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
